// File: rtl/fu_cdb_tx_queue.sv
// Per-FU writeback queue: buffers completed FU results in a small circular FIFO
// and presents the oldest one as a CDB request until the arbiter grants it.
package fu_cdb_pkg;
   typedef struct packed {
      logic [3:0]  fu_op;
      logic [4:0]  dest_reg;
      logic [5:0]  tag;
      logic [31:0] result;
   } FU_PACKET;
endpackage

module fu_cdb_tx_queue
   import fu_cdb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  FU_PACKET         in_packet,
   output logic             in_ready,
   input  logic             squash,
   output logic             fu_done,
   output FU_PACKET         wr_data,
   input  logic             stall_sig,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   FU_PACKET         mem_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;

   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic [CNT_W-1:0] count_nxt_s;

   // Handshake decode; ready/request depend only on registered occupancy, never on stall_sig.
   always_comb begin
      full_s      = (count_r == FULL_CNT);
      empty_s     = (count_r == {CNT_W{1'b0}});
      push_s      = in_valid & ~full_s & ~squash;
      pop_s       = ~empty_s & ~stall_sig & ~squash;
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer and occupancy state; squash outranks any push or pop in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (squash) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // Entry storage is deliberately left uncleared; only pointers define validity.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[tail_r] <= in_packet;
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      in_ready = ~full_s;
      fu_done  = ~empty_s;
      count    = count_r;
      if (!empty_s) begin
         wr_data = mem_r[head_r];
      end else begin
         wr_data = '0;
      end
   end

`ifdef DEBUG
   // Debug-only notice when the FU offers a result the queue cannot take.
   always_ff @(posedge clock) begin
      if (reset && in_valid && full_s && !squash) begin
         $warning("fu_cdb_tx_queue: push while full, packet must be held by FU");
      end
   end
`endif

endmodule

// File: tb/tb_fu_cdb_tx_queue.sv
// Directed self-checking bench for fu_cdb_tx_queue (DEPTH = 4).
module tb_fu_cdb_tx_queue;
   import fu_cdb_pkg::*;

   logic       clock;
   logic       reset;
   logic       in_valid;
   FU_PACKET   in_packet;
   logic       in_ready;
   logic       squash;
   logic       fu_done;
   FU_PACKET   wr_data;
   logic       stall_sig;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   fu_cdb_tx_queue #(.DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_packet (in_packet),
      .in_ready  (in_ready),
      .squash    (squash),
      .fu_done   (fu_done),
      .wr_data   (wr_data),
      .stall_sig (stall_sig),
      .count     (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic FU_PACKET mk(input logic [31:0] r);
      FU_PACKET p;
      p.fu_op    = r[3:0] ^ 4'h5;
      p.dest_reg = r[4:0];
      p.tag      = r[5:0] + 6'd1;
      p.result   = r;
      return p;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      FU_PACKET zero_pkt;
      zero_pkt = '0;
      #1;
      n_checks++;
      if (count !== 3'd0 || fu_done !== 1'b0 || in_ready !== 1'b1 || wr_data !== zero_pkt) begin
         n_fail++;
         $display("FAIL reset_init: count=%0d fu_done=%b in_ready=%b wr_data=%h, required 0/0/1/0", count, fu_done, in_ready, wr_data);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      // stall while empty must not disturb anything
      stall_sig = 1'b1;
      tick();
      n_checks++;
      if (count !== 3'd0 || fu_done !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_stall: count=%0d fu_done=%b, required 0/0", count, fu_done);
      end
      stall_sig = 1'b0;
   endtask

   task automatic test_in_order_drain();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      n_checks++;
      if (fu_done !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_pre: fu_done=%b, required 0", fu_done);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_packet = mk(vals[i]);
         tick();
         n_checks++;
         if (fu_done !== 1'b1 || wr_data !== mk(vals[i])) begin
            n_fail++;
            $display("FAIL drain_order[%0d]: fu_done=%b result=%h, required 1/%h", i, fu_done, wr_data.result, vals[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (fu_done !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL drain_empty: fu_done=%b count=%0d, required 0/0", fu_done, count);
      end
   endtask

   task automatic test_stall_hold();
      stall_sig = 1'b1;
      in_valid  = 1'b1;
      in_packet = mk(32'hAA);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stall_sig = (i < 5) ? 1'b1 : 1'b0;
         n_checks++;
         if (fu_done !== 1'b1 || wr_data !== mk(32'hAA) || count !== 3'd1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: fu_done=%b result=%h count=%0d, required 1/aa/1", i, fu_done, wr_data.result, count);
         end
         tick();
      end
      n_checks++;
      if (count !== 3'd0 || fu_done !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_retire: count=%0d fu_done=%b, required 0/0", count, fu_done);
      end
   endtask

   task automatic test_full_backpressure();
      stall_sig = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_packet = mk(32'(i));
         tick();
         if (i == 4) begin
            n_checks++;
            if (count !== 3'd4 || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL full_after4: count=%0d in_ready=%b, required 4/0", count, in_ready);
            end
         end
      end
      n_checks++;
      if (count !== 3'd4 || wr_data !== mk(32'h01)) begin
         n_fail++;
         $display("FAIL full_drop: count=%0d head=%h, required 4/01", count, wr_data.result);
      end
      // release stall, 0x05 still offered
      stall_sig = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         n_checks++;
         if (fu_done !== 1'b1 || wr_data !== mk(32'(j))) begin
            n_fail++;
            $display("FAIL full_drain[%0d]: fu_done=%b result=%h, required 1/%h", j, fu_done, wr_data.result, j);
         end
         if (j == 1 || j == 2) begin
            n_checks++;
            if (in_ready !== (j == 2)) begin
               n_fail++;
               $display("FAIL full_ready[%0d]: in_ready=%b, required %b", j, in_ready, (j == 2));
            end
         end
         tick();
         if (j == 2) in_valid = 1'b0;
      end
      n_checks++;
      if (fu_done !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL full_end: fu_done=%b count=%0d, required 0/0", fu_done, count);
      end
   endtask

   task automatic test_wrap_push_pop();
      logic [31:0] exp_q [$];
      stall_sig = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_packet = mk(32'hA0 + 32'(i));
         exp_q.push_back(32'hA0 + 32'(i));
         tick();
      end
      stall_sig = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_packet = mk(32'hB0 + 32'(i));
         n_checks++;
         if (count !== 3'd2 || wr_data !== mk(exp_q[0])) begin
            n_fail++;
            $display("FAIL wrap[%0d]: count=%0d result=%h, required 2/%h", i, count, wr_data.result, exp_q[0]);
         end
         void'(exp_q.pop_front());
         exp_q.push_back(32'hB0 + 32'(i));
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (wr_data !== mk(exp_q[0])) begin
            n_fail++;
            $display("FAIL wrap_tail[%0d]: result=%h, required %h", i, wr_data.result, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick();
      end
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL wrap_end: count=%0d, required 0", count);
      end
   endtask

   task automatic test_squash();
      FU_PACKET zero_pkt;
      zero_pkt  = '0;
      stall_sig = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_packet = mk(32'hC0 + 32'(i));
         tick();
      end
      squash    = 1'b1;
      stall_sig = 1'b0;
      in_packet = mk(32'h99);
      tick();
      squash   = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (count !== 3'd0 || fu_done !== 1'b0 || wr_data !== zero_pkt) begin
         n_fail++;
         $display("FAIL squash_clear: count=%0d fu_done=%b result=%h, required 0/0/0", count, fu_done, wr_data.result);
      end
      in_valid  = 1'b1;
      in_packet = mk(32'h77);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (fu_done !== 1'b1 || wr_data !== mk(32'h77) || count !== 3'd1) begin
         n_fail++;
         $display("FAIL squash_next: fu_done=%b result=%h count=%0d, required 1/77/1", fu_done, wr_data.result, count);
      end
      tick();
   endtask

   task automatic test_reset_midcycle();
      FU_PACKET zero_pkt;
      zero_pkt  = '0;
      stall_sig = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_packet = mk(32'hD0 + 32'(i));
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL rst_pre: count=%0d, required 3", count);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd0 || fu_done !== 1'b0 || in_ready !== 1'b1 || wr_data !== zero_pkt) begin
         n_fail++;
         $display("FAIL rst_async: count=%0d fu_done=%b in_ready=%b result=%h, required 0/0/1/0", count, fu_done, in_ready, wr_data.result);
      end
      tick();
      reset     = 1'b1;
      stall_sig = 1'b0;
      tick();
      n_checks++;
      if (count !== 3'd0 || fu_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after: count=%0d fu_done=%b, required 0/0", count, fu_done);
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_packet = '0;
      squash    = 1'b0;
      stall_sig = 1'b0;
      test_reset();
      test_in_order_drain();
      test_stall_hold();
      test_full_backpressure();
      test_wrap_push_pop();
      test_squash();
      test_reset_midcycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
